// File: rtl/mem_port_arbiter_pkg.sv
// Shared encodings for the memory port arbiter and its timer.
package mem_port_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT_I = 2'd1,
        ST_GRANT_D = 2'd2
    } arb_state_e;

    localparam logic [2:0] COP_RD = 3'b000;
    localparam logic [2:0] COP_WR = 3'b001;

    localparam logic [2:0] SIZE_B = 3'b000;
    localparam logic [2:0] SIZE_H = 3'b001;
    localparam logic [2:0] SIZE_W = 3'b010;

    localparam logic [31:0] DEF_TIMEOUT_RDATA = 32'hDEAD_BEEF;

endpackage

// File: rtl/mem_arb_timer.sv
// Per-transaction wait counter; expire_o flags the last allowed cycle (LIMIT=0 never expires).
module mem_arb_timer #(
    parameter int unsigned LIMIT = 64
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run_i,
    input  logic clear_i,
    output logic expire_o
);

    logic [7:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (run_i) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    always_comb begin
        expire_o = 1'b0;
        if (LIMIT != 0) begin
            expire_o = run_i && (cnt_q == 8'(LIMIT - 1));
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one memory port between instruction and data requesters: data priority,
// bounded data streak while a fetch waits, grant held to completion, ack timeout.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int unsigned        ADDR_W        = 32,
    parameter int unsigned        MAX_D_STREAK  = 4,
    parameter int unsigned        TIMEOUT       = 64,
    parameter logic [2:0]         I_SIZE        = SIZE_W,
    parameter logic [ADDR_W-1:0]  TIMEOUT_RDATA = ADDR_W'(DEF_TIMEOUT_RDATA)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_req_val,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_req_ack,
    output logic [ADDR_W-1:0] i_ack_rdata,
    input  logic              d_req_val,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [2:0]        d_req_cop,
    input  logic [ADDR_W-1:0] d_req_wdata,
    input  logic [2:0]        d_req_size,
    output logic              d_req_ack,
    output logic [ADDR_W-1:0] d_ack_rdata,
    output logic              m_req_val,
    output logic [ADDR_W-1:0] m_req_addr,
    output logic [2:0]        m_req_cop,
    output logic [ADDR_W-1:0] m_req_wdata,
    output logic [2:0]        m_req_size,
    input  logic              m_req_ack,
    input  logic [ADDR_W-1:0] m_ack_rdata,
    output logic              err_timeout
);

    arb_state_e        state_q;
    logic [3:0]        streak_q;
    logic              err_q;
    logic              granted;
    logic              expire;
    logic              done;
    logic [ADDR_W-1:0] ack_data;

    assign granted = (state_q != ST_IDLE);
    assign done    = granted && (m_req_ack || expire);

    mem_arb_timer #(
        .LIMIT (TIMEOUT)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .run_i    (granted),
        .clear_i  (done),
        .expire_o (expire)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= ST_IDLE;
            streak_q <= '0;
            err_q    <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (d_req_val && (!i_req_val || streak_q < 4'(MAX_D_STREAK))) begin
                        state_q <= ST_GRANT_D;
                        if (!i_req_val) begin
                            streak_q <= '0;
                        end else if (streak_q < 4'(MAX_D_STREAK)) begin
                            streak_q <= streak_q + 4'd1;
                        end
                    end else if (i_req_val) begin
                        state_q  <= ST_GRANT_I;
                        streak_q <= '0;
                    end
                end
                ST_GRANT_I, ST_GRANT_D: begin
                    if (m_req_ack) begin
                        state_q <= ST_IDLE;
                    end else if (expire) begin
                        state_q <= ST_IDLE;
                        err_q   <= 1'b1;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // A real ack on the expiry cycle takes precedence over the timeout data.
    assign ack_data = m_req_ack ? m_ack_rdata : TIMEOUT_RDATA;

    always_comb begin
        m_req_val   = granted;
        m_req_addr  = '0;
        m_req_cop   = COP_RD;
        m_req_wdata = '0;
        m_req_size  = '0;
        i_req_ack   = 1'b0;
        i_ack_rdata = '0;
        d_req_ack   = 1'b0;
        d_ack_rdata = '0;
        if (state_q == ST_GRANT_I) begin
            m_req_addr = i_req_addr;
            m_req_size = I_SIZE;
            if (done) begin
                i_req_ack   = 1'b1;
                i_ack_rdata = ack_data;
            end
        end else if (state_q == ST_GRANT_D) begin
            m_req_addr  = d_req_addr;
            m_req_cop   = d_req_cop;
            m_req_wdata = d_req_wdata;
            m_req_size  = d_req_size;
            if (done) begin
                d_req_ack   = 1'b1;
                d_ack_rdata = ack_data;
            end
        end
    end

    assign err_timeout = err_q;

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
Shares one downstream memory port between the core's instruction request channel and data request channel. It sits between core_top and the single-ported memory/bus bridge. It arbitrates with data priority and a bounded starvation guard for instruction fetch, holds the grant until the transaction completes, and enforces a per-transaction ack timeout.

Parameters:
ADDR_W, 32, address and data width
MAX_D_STREAK, 4, consecutive data grants allowed while an instruction request is pending (1..15)
TIMEOUT, 64, cycles to wait for m_req_ack before forced completion; 0 disables (max 255)
I_SIZE, 3'b010, size code driven for instruction fetches (word)
TIMEOUT_RDATA, 32'hDEAD_BEEF, read data returned on timeout

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
i_req_val  in  1  instruction request valid
i_req_addr  in  ADDR_W  instruction address
i_req_ack  out  1  instruction transaction complete (1-cycle pulse)
i_ack_rdata  out  ADDR_W  fetch data, valid with i_req_ack
d_req_val  in  1  data request valid
d_req_addr  in  ADDR_W  data address
d_req_cop  in  3  3'b000 read, 3'b001 write
d_req_wdata  in  ADDR_W  write data
d_req_size  in  3  access size code
d_req_ack  out  1  data transaction complete (1-cycle pulse)
d_ack_rdata  out  ADDR_W  load data, valid with d_req_ack
m_req_val  out  1  downstream request valid
m_req_addr  out  ADDR_W  downstream address
m_req_cop  out  3  downstream operation
m_req_wdata  out  ADDR_W  downstream write data
m_req_size  out  3  downstream size
m_req_ack  in  1  downstream completion pulse
m_ack_rdata  in  ADDR_W  downstream read data, valid with m_req_ack
err_timeout  out  1  sticky: a transaction timed out

Behaviour:
- One clock; reset synchronous, active-low. On rst_n=0: state IDLE, streak=0, wait=0, err_timeout=0. All outputs 0 during and after reset until a grant.
- FSM states: IDLE, GRANT_I, GRANT_D.
- IDLE: m_req_val=0, m_req_* fields=0, both acks 0. Next state:
  - GRANT_D if d_req_val and (!i_req_val or streak<MAX_D_STREAK).
  - Else GRANT_I if i_req_val.
  - Else stay in IDLE.
- Grant takes effect the cycle after the request is seen, so minimum latency from val to m_req_val is 1 cycle.
- Streak counter, updated on the IDLE->grant transition:
  - GRANT_D with i_req_val=1: streak+1, saturating at MAX_D_STREAK.
  - GRANT_D with i_req_val=0: streak=0.
  - GRANT_I: streak=0.
- GRANT_x: m_req_val=1. m_req_addr/cop/wdata/size follow the granted requester combinationally.
  - Instruction grant drives cop=3'b000, size=I_SIZE, wdata=0.
  - The requester must hold val and fields stable until its ack; a grant is never revoked early.
- Completion: in the cycle m_req_ack=1, pulse x_req_ack=1 with x_ack_rdata=m_ack_rdata (combinational). Next state IDLE, wait=0. Exactly one idle bubble between transactions.
- Non-granted requester: ack=0, rdata=0 at all times.
- Timeout (TIMEOUT>0): wait counts cycles in GRANT_x.
  - When wait==TIMEOUT-1 and m_req_ack=0: pulse x_req_ack with rdata=TIMEOUT_RDATA, set err_timeout, go to IDLE.
  - A real ack in the same cycle wins: normal completion, no error.
- err_timeout is cleared only by reset.
- An m_req_ack arriving in IDLE is ignored and not forwarded.
- A reset asserted mid-transaction aborts it with no ack; downstream sees m_req_val drop the next cycle.

Decomposition:
- Shared package/header: FSM state encoding, cop codes (COP_RD=3'b000, COP_WR=3'b001), size codes, and the default TIMEOUT_RDATA value.
- Natural sub-module: mem_arb_timer, the wait counter with load/clear/expire outputs. Its reuse is expected in the bus bridge.

Test Plan:
- Lone fetch: i_req_val=1, addr 0x100; memory acks 2 cycles after m_req_val with 0x00000013 -> m_req_addr=0x100, cop=000, size=010; i_req_ack pulses once with rdata 0x00000013; next grant no earlier than 1 idle cycle later.
- Simultaneous requests: i and d both valid, d is a write of 0xCAFEF00D to 0x2000 -> data is granted first with m_req_cop=001 and m_req_wdata=0xCAFEF00D; instruction is granted after d_req_ack.
- Starvation guard: d_req_val and i_req_val held high continuously, MAX_D_STREAK=4 -> grant sequence D,D,D,D,I,D,D,D,D,I.
- Timeout: TIMEOUT=8, m_req_ack never asserted on a data read -> d_req_ack pulses 8 cycles after grant with rdata 0xDEADBEEF; err_timeout=1 and stays set.
- Ack on the expiry cycle: m_req_ack asserted exactly at wait==TIMEOUT-1 with 0x55 -> normal ack with rdata 0x55; err_timeout stays 0.
- Reset mid-transaction: rst_n low for 1 cycle during GRANT_D -> no d_req_ack; m_req_val=0 the next cycle; err_timeout=0; streak reset (subsequent simultaneous requests grant D first).
